mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module      : mem_arbiter_if
// Description : Two-requester / single-RAM bus bundle for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int DATA_BITS = 32,
  parameter int MEM_ADDR  = 10
);
  logic                 r0_req;
  logic                 r0_we;
  logic [MEM_ADDR-1:0]  r0_addr;
  logic [DATA_BITS-1:0] r0_wdata;
  logic                 r0_gnt;
  logic                 r0_rvalid;
  logic [DATA_BITS-1:0] r0_rdata;

  logic                 r1_req;
  logic                 r1_we;
  logic [MEM_ADDR-1:0]  r1_addr;
  logic [DATA_BITS-1:0] r1_wdata;
  logic                 r1_gnt;
  logic                 r1_rvalid;
  logic [DATA_BITS-1:0] r1_rdata;

  logic                 mem_en;
  logic                 mem_we;
  logic [MEM_ADDR-1:0]  mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;

  // Requesters plus the RAM model sit on the master side.
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port arbiter in front of a single-port synchronous RAM.
//               Fixed priority with burst limit by default; define
//               ARB_ROUND_ROBIN_EN for alternate-on-contention arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int DATA_BITS = 32,
  parameter int MEM_ADDR  = 10,
  parameter int MAX_BURST = 4
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int                 c_cnt_w     = $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);
  localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_burst;
  logic               r_rd0;
  logic               r_rd1;

  logic               w_pick1;
  logic               w_gnt0;
  logic               w_gnt1;

  // w_pick1 decides contention only; a lone requester always wins.
`ifdef ARB_ROUND_ROBIN_EN
  assign w_pick1 = (r_state == OWN0);
`else
  assign w_pick1 = (r_state == OWN0) && (r_burst == c_max_burst);
`endif

  assign w_gnt0 = rst_n & bus.r0_req & ~(bus.r1_req &  w_pick1);
  assign w_gnt1 = rst_n & bus.r1_req & ~(bus.r0_req & ~w_pick1);

  assign bus.r0_gnt = w_gnt0;
  assign bus.r1_gnt = w_gnt1;

  always_comb begin
    bus.mem_en    = w_gnt0 | w_gnt1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {MEM_ADDR{1'b0}};
    bus.mem_wdata = {DATA_BITS{1'b0}};
    if (w_gnt1) begin
      bus.mem_we    = bus.r1_we;
      bus.mem_addr  = bus.r1_addr;
      bus.mem_wdata = bus.r1_wdata;
    end else if (w_gnt0) begin
      bus.mem_we    = bus.r0_we;
      bus.mem_addr  = bus.r0_addr;
      bus.mem_wdata = bus.r0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_burst <= '0;
      r_rd0   <= 1'b0;
      r_rd1   <= 1'b0;
    end else begin
      r_rd0 <= w_gnt0 & ~bus.r0_we;
      r_rd1 <= w_gnt1 & ~bus.r1_we;
      if (w_gnt0) begin
        r_state <= OWN0;
        if (r_state != OWN0)
          r_burst <= c_one;
        else if (r_burst != c_max_burst)
          r_burst <= r_burst + c_one;
      end else if (w_gnt1) begin
        r_state <= OWN1;
        if (r_state != OWN1)
          r_burst <= c_one;
        else if (r_burst != c_max_burst)
          r_burst <= r_burst + c_one;
      end else begin
        r_state <= IDLE;
        r_burst <= '0;
      end
    end
  end

  // Gating with rst_n drops a read that was in flight when reset arrives.
  assign bus.r0_rvalid = r_rd0 & rst_n;
  assign bus.r1_rvalid = r_rd1 & rst_n;
  assign bus.r0_rdata  = bus.mem_rdata;
  assign bus.r1_rdata  = bus.mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (directed + randomized).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_BITS(DW), .MEM_ADDR(AW)) bus ();

  mem_arbiter #(.DATA_BITS(DW), .MEM_ADDR(AW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Single-port synchronous RAM seen by the arbiter.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.r0_req = req; bus.r0_we = we; bus.r0_addr = a; bus.r0_wdata = d;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.r1_req = req; bus.r1_we = we; bus.r1_addr = a; bus.r1_wdata = d;
  endtask

  task automatic apply_reset;
    cyc();
    rst_n = 1'b0;
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    drive0(1'b1, 1'b0, 10'h001, '0);
    drive1(1'b1, 1'b0, 10'h002, '0);
    @(negedge clk);
    checks++; if (bus.r0_gnt !== 1'b0) $display("FAIL rst_gnt0: got %b want 0", bus.r0_gnt); else passes++;
    checks++; if (bus.r1_gnt !== 1'b0) $display("FAIL rst_gnt1: got %b want 0", bus.r1_gnt); else passes++;
    checks++; if (bus.mem_en !== 1'b0) $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); else passes++;
    cyc();
    @(negedge clk);
    checks++; if (bus.r0_rvalid !== 1'b0) $display("FAIL rst_rvalid0: got %b want 0", bus.r0_rvalid); else passes++;
    checks++; if (bus.r1_rvalid !== 1'b0) $display("FAIL rst_rvalid1: got %b want 0", bus.r1_rvalid); else passes++;
  endtask

  task automatic test_single_read;
    apply_reset();
    drive1(1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (bus.r1_gnt !== 1'b1) $display("FAIL preload_gnt1: got %b want 1", bus.r1_gnt); else passes++;
    cyc();
    drive1(1'b0, 1'b0, '0, '0);
    drive0(1'b1, 1'b0, 10'h005, '0);
    @(negedge clk);
    checks++; if (bus.r0_gnt !== 1'b1) $display("FAIL rd_gnt0: got %b want 1", bus.r0_gnt); else passes++;
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0) $display("FAIL rd_mem_ctl: en=%b we=%b want en=1 we=0", bus.mem_en, bus.mem_we); else passes++;
    checks++; if (bus.mem_addr !== 10'h005) $display("FAIL rd_mem_addr: got %h want 005", bus.mem_addr); else passes++;
    checks++; if (bus.r1_rvalid !== 1'b0) $display("FAIL wr_no_rvalid: got %b want 0", bus.r1_rvalid); else passes++;
    cyc();
    drive0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (bus.r0_rvalid !== 1'b1) $display("FAIL rd_rvalid0: got %b want 1", bus.r0_rvalid); else passes++;
    checks++; if (bus.r0_rdata !== 32'hDEADBEEF) $display("FAIL rd_rdata0: got %h want deadbeef", bus.r0_rdata); else passes++;
    checks++; if (bus.r1_rvalid !== 1'b0) $display("FAIL rd_rvalid1: got %b want 0", bus.r1_rvalid); else passes++;
    cyc();
    @(negedge clk);
    checks++; if (bus.r0_rvalid !== 1'b0) $display("FAIL rd_rvalid_once: got %b want 0", bus.r0_rvalid); else passes++;
  endtask

  task automatic test_write_then_read;
    apply_reset();
    drive1(1'b1, 1'b1, 10'h3FF, 32'h12345678);
    @(negedge clk);
    checks++; if (bus.r1_gnt !== 1'b1) $display("FAIL wr_gnt1: got %b want 1", bus.r1_gnt); else passes++;
    checks++; if (bus.mem_we !== 1'b1) $display("FAIL wr_mem_we: got %b want 1", bus.mem_we); else passes++;
    checks++; if (bus.mem_addr !== 10'h3FF || bus.mem_wdata !== 32'h12345678)
      $display("FAIL wr_mem_bus: got %h/%h want 3ff/12345678", bus.mem_addr, bus.mem_wdata); else passes++;
    cyc();
    drive1(1'b0, 1'b0, '0, '0);
    drive0(1'b1, 1'b0, 10'h3FF, '0);
    @(negedge clk);
    checks++; if (bus.r0_gnt !== 1'b1) $display("FAIL wr_rd_gnt0: got %b want 1", bus.r0_gnt); else passes++;
    cyc();
    drive0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (bus.r0_rvalid !== 1'b1 || bus.r0_rdata !== 32'h12345678)
      $display("FAIL wr_rd_data: got v=%b %h want v=1 12345678", bus.r0_rvalid, bus.r0_rdata); else passes++;
  endtask

  task automatic test_contention;
    int  n;
    bit  want1;
`ifdef ARB_ROUND_ROBIN_EN
    n = 6;
`else
    n = 12;
`endif
    apply_reset();
    drive0(1'b1, 1'b0, 10'h001, '0);
    drive1(1'b1, 1'b0, 10'h002, '0);
    for (int i = 0; i < n; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      want1 = (i % 2) == 1;
`else
      want1 = (i % (MB + 1)) == MB;
`endif
      @(negedge clk);
      checks++;
      if (bus.r0_gnt !== !want1 || bus.r1_gnt !== want1)
        $display("FAIL contention[%0d]: got gnt0=%b gnt1=%b want gnt0=%b gnt1=%b", i, bus.r0_gnt, bus.r1_gnt, !want1, want1);
      else passes++;
      cyc();
    end
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_inflight;
    apply_reset();
    drive1(1'b1, 1'b0, 10'h007, '0);
    @(negedge clk);
    checks++; if (bus.r1_gnt !== 1'b1) $display("FAIL inflight_gnt1: got %b want 1", bus.r1_gnt); else passes++;
    cyc();
    rst_n = 1'b0;
    drive0(1'b1, 1'b0, 10'h008, '0);
    @(negedge clk);
    checks++; if (bus.r1_rvalid !== 1'b0) $display("FAIL inflight_rvalid1: got %b want 0", bus.r1_rvalid); else passes++;
    checks++; if (bus.mem_en !== 1'b0) $display("FAIL inflight_mem_en: got %b want 0", bus.mem_en); else passes++;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.r1_rvalid !== 1'b0) $display("FAIL post_rst_rvalid1: got %b want 0", bus.r1_rvalid); else passes++;
    checks++; if (bus.r0_gnt !== 1'b1 || bus.r1_gnt !== 1'b0)
      $display("FAIL post_rst_first: got gnt0=%b gnt1=%b want 1/0", bus.r0_gnt, bus.r1_gnt); else passes++;
    cyc();
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
  endtask

`ifndef ARB_ROUND_ROBIN_EN
  task automatic test_cancel;
    apply_reset();
    drive0(1'b1, 1'b0, 10'h003, '0);
    for (int i = 0; i < 6; i++) begin
      if (i == 1) drive1(1'b1, 1'b1, 10'h009, 32'hAAAA5555);
      if (i == 3) drive1(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      checks++;
      if (bus.r1_gnt !== 1'b0 || bus.mem_we !== 1'b0 || bus.r1_rvalid !== 1'b0)
        $display("FAIL cancel[%0d]: got gnt1=%b we=%b rvalid1=%b want 0/0/0", i, bus.r1_gnt, bus.mem_we, bus.r1_rvalid);
      else passes++;
      cyc();
    end
    drive0(1'b0, 1'b0, '0, '0);
  endtask
`endif

  task automatic test_random;
    int            owner = -1;
    int            run   = 0;
    int            eg;
    bit            pend0 = 0, pend1 = 0;
    bit            pv0 = 0, pv1 = 0, pk0 = 0, pk1 = 0;
    logic [DW-1:0] pd0 = '0, pd1 = '0;
    logic [DW-1:0] shadow [0:15];
    bit            known  [0:15];
    for (int k = 0; k < 16; k++) begin
      known[k]  = 0;
      shadow[k] = '0;
    end
    apply_reset();
    for (int t = 0; t < 400; t++) begin
      if (pend0) begin
        if ($urandom_range(7) == 0) bus.r0_req = 1'b0;
      end else
        drive0($urandom_range(9) < 6, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom);
      if (pend1) begin
        if ($urandom_range(7) == 0) bus.r1_req = 1'b0;
      end else
        drive1($urandom_range(9) < 6, 1'($urandom_range(1)), AW'($urandom_range(15)), $urandom);
      @(negedge clk);

      // Reference decision: lone requester wins; contention per selected policy.
      if (bus.r0_req && !bus.r1_req)      eg = 0;
      else if (bus.r1_req && !bus.r0_req) eg = 1;
      else if (bus.r0_req && bus.r1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        eg = (owner == 0) ? 1 : 0;
`else
        eg = (owner == 0 && run >= MB) ? 1 : 0;
`endif
      end else eg = -1;

      checks++;
      if (bus.r0_gnt !== (eg == 0) || bus.r1_gnt !== (eg == 1) || bus.mem_en !== (eg != -1))
        $display("FAIL rnd_gnt[%0d]: got gnt0=%b gnt1=%b en=%b want grant to %0d", t, bus.r0_gnt, bus.r1_gnt, bus.mem_en, eg);
      else passes++;
      checks++;
      if (eg == 0 && (bus.mem_we !== bus.r0_we || bus.mem_addr !== bus.r0_addr || (bus.r0_we && bus.mem_wdata !== bus.r0_wdata)))
        $display("FAIL rnd_bus0[%0d]: got we=%b a=%h d=%h want we=%b a=%h d=%h", t, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.r0_we, bus.r0_addr, bus.r0_wdata);
      else if (eg == 1 && (bus.mem_we !== bus.r1_we || bus.mem_addr !== bus.r1_addr || (bus.r1_we && bus.mem_wdata !== bus.r1_wdata)))
        $display("FAIL rnd_bus1[%0d]: got we=%b a=%h d=%h want we=%b a=%h d=%h", t, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.r1_we, bus.r1_addr, bus.r1_wdata);
      else if (eg == -1 && bus.mem_we !== 1'b0)
        $display("FAIL rnd_idle_we[%0d]: got %b want 0", t, bus.mem_we);
      else passes++;
      checks++;
      if (bus.r0_rvalid !== pv0 || bus.r1_rvalid !== pv1)
        $display("FAIL rnd_rvalid[%0d]: got %b%b want %b%b", t, bus.r0_rvalid, bus.r1_rvalid, pv0, pv1);
      else passes++;
      if (pv0 && pk0) begin
        checks++;
        if (bus.r0_rdata !== pd0) $display("FAIL rnd_rdata0[%0d]: got %h want %h", t, bus.r0_rdata, pd0); else passes++;
      end
      if (pv1 && pk1) begin
        checks++;
        if (bus.r1_rdata !== pd1) $display("FAIL rnd_rdata1[%0d]: got %h want %h", t, bus.r1_rdata, pd1); else passes++;
      end

      pv0 = (eg == 0) && !bus.r0_we;
      pv1 = (eg == 1) && !bus.r1_we;
      if (pv0) begin pd0 = shadow[bus.r0_addr[3:0]]; pk0 = known[bus.r0_addr[3:0]]; end
      if (pv1) begin pd1 = shadow[bus.r1_addr[3:0]]; pk1 = known[bus.r1_addr[3:0]]; end
      if (eg == 0 && bus.r0_we) begin shadow[bus.r0_addr[3:0]] = bus.r0_wdata; known[bus.r0_addr[3:0]] = 1; end
      if (eg == 1 && bus.r1_we) begin shadow[bus.r1_addr[3:0]] = bus.r1_wdata; known[bus.r1_addr[3:0]] = 1; end
      if (eg == -1) begin owner = -1; run = 0; end
      else if (eg == owner) run = (run < MB) ? run + 1 : MB;
      else begin owner = eg; run = 1; end
      pend0 = bus.r0_req && (eg != 0);
      pend1 = bus.r1_req && (eg != 1);
      cyc();
    end
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    drive0(1'b0, 1'b0, '0, '0);
    drive1(1'b0, 1'b0, '0, '0);
    test_reset();
    test_single_read();
    test_write_then_read();
    test_contention();
    test_reset_inflight();
`ifndef ARB_ROUND_ROBIN_EN
    test_cancel();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
